// File: rtl/rc_pkt_assembler.sv
// Receive-side USB packet assembler: deserialises the CRC-checked bit stream into a
// PID byte and payload word, then classifies and flags the packet at end of packet.
module rc_pkt_assembler #(
  parameter int PAYLOAD_BITS = 64,
  parameter int CRC_BITS     = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    s_in,
  input  logic                    s_valid,
  input  logic                    start_asm,
  input  logic                    end_asm,
  input  logic                    abort,
  input  logic                    rc_CRCerror,
  input  logic                    receive_data,
  input  logic                    receive_hshake,
  output logic [7:0]              pid,
  output logic [PAYLOAD_BITS-1:0] data,
  output logic                    pkt_valid,
  output logic                    pkt_ok,
  output logic                    pid_err,
  output logic                    len_err,
  output logic                    crc_err,
  output logic                    kind_err,
  output logic                    asm_busy
);

  localparam int DATA_LEN = 8 + PAYLOAD_BITS + CRC_BITS;
  localparam int DIDX_W   = $clog2(PAYLOAD_BITS);

  localparam logic [7:0] PID_DATA0 = 8'hC3;
  localparam logic [7:0] PID_DATA1 = 8'h4B;
  localparam logic [7:0] PID_ACK   = 8'hD2;
  localparam logic [7:0] PID_NAK   = 8'h5A;
  localparam logic [7:0] PID_STALL = 8'h1E;

  typedef enum logic [1:0] {
    S_IDLE,
    S_PID,
    S_BODY
  } state_t;

  state_t                  state;
  logic [6:0]              bit_cnt;

  logic                    accept;
  logic [6:0]              cnt_nxt;
  logic [7:0]              pid_nxt;
  logic [PAYLOAD_BITS-1:0] data_nxt;
  logic [DIDX_W-1:0]       data_idx;

  logic                    is_data;
  logic                    is_hshake;
  logic                    pid_bad;
  logic                    len_bad;
  logic                    crc_bad;
  logic                    kind_bad;

  assign accept   = s_valid && (state != S_IDLE);
  assign data_idx = DIDX_W'(bit_cnt - 7'd8);

  // Post-acceptance view of the packet, so a bit landing together with end_asm
  // is included in the end-of-packet evaluation.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    cnt_nxt  = bit_cnt;
    pid_nxt  = pid;
    data_nxt = data;
    if (accept) begin
      if (bit_cnt < 7'd8)
        pid_nxt[bit_cnt[2:0]] = s_in;
      else if (bit_cnt < 7'(8 + PAYLOAD_BITS))
        data_nxt[data_idx] = s_in;
      if (bit_cnt != 7'd127)
        cnt_nxt = bit_cnt + 7'd1;
    end
  end

  always_comb begin
    is_data   = (pid_nxt == PID_DATA0) || (pid_nxt == PID_DATA1);
    is_hshake = (pid_nxt == PID_ACK) || (pid_nxt == PID_NAK) || (pid_nxt == PID_STALL);
    pid_bad   = (pid_nxt[7:4] != ~pid_nxt[3:0]) || !(is_data || is_hshake);
    len_bad   = pid_bad
             || (is_data   && (cnt_nxt != 7'(DATA_LEN)))
             || (is_hshake && (cnt_nxt != 7'd8));
    crc_bad   = rc_CRCerror && is_data;
    kind_bad  = !pid_bad && ((is_data && !receive_data) || (is_hshake && !receive_hshake));
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      bit_cnt   <= '0;
      pid       <= '0;
      data      <= '0;
      pkt_valid <= 1'b0;
      pkt_ok    <= 1'b0;
      pid_err   <= 1'b0;
      len_err   <= 1'b0;
      crc_err   <= 1'b0;
      kind_err  <= 1'b0;
      asm_busy  <= 1'b0;
    end else begin
      pkt_valid <= 1'b0;
      pkt_ok    <= 1'b0;
      if (start_asm) begin
        // A start always wins: any packet in flight is dropped silently.
        state    <= S_PID;
        bit_cnt  <= '0;
        pid      <= '0;
        data     <= '0;
        pid_err  <= 1'b0;
        len_err  <= 1'b0;
        crc_err  <= 1'b0;
        kind_err <= 1'b0;
        asm_busy <= 1'b1;
      end else if (state != S_IDLE) begin
        bit_cnt <= cnt_nxt;
        pid     <= pid_nxt;
        data    <= data_nxt;
        if (abort) begin
          state    <= S_IDLE;
          asm_busy <= 1'b0;
        end else if (end_asm) begin
          state     <= S_IDLE;
          asm_busy  <= 1'b0;
          pkt_valid <= 1'b1;
          pkt_ok    <= !(pid_bad || len_bad || crc_bad || kind_bad);
          pid_err   <= pid_bad;
          len_err   <= len_bad;
          crc_err   <= crc_bad;
          kind_err  <= kind_bad;
        end else if ((state == S_PID) && accept && (bit_cnt == 7'd7)) begin
          state <= S_BODY;
        end
      end
    end
  end

endmodule

// File: tb/tb_rc_pkt_assembler.sv
// Randomised and directed bench for rc_pkt_assembler against a packet-level model
// that derives the expected PID, payload and flags from the transmitted bit list.
module tb_rc_pkt_assembler;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        s_in, s_valid, start_asm, end_asm, abort, rc_CRCerror;
  logic        receive_data, receive_hshake;
  logic [7:0]  pid;
  logic [63:0] data;
  logic        pkt_valid, pkt_ok, pid_err, len_err, crc_err, kind_err, asm_busy;

  int checks = 0;
  int errors = 0;
  int vld_cnt = 0;
  bit pkt_q[$];

  rc_pkt_assembler #(.PAYLOAD_BITS(64), .CRC_BITS(16)) dut (
    .clk(clk), .rst_n(rst_n), .s_in(s_in), .s_valid(s_valid),
    .start_asm(start_asm), .end_asm(end_asm), .abort(abort),
    .rc_CRCerror(rc_CRCerror), .receive_data(receive_data),
    .receive_hshake(receive_hshake), .pid(pid), .data(data),
    .pkt_valid(pkt_valid), .pkt_ok(pkt_ok), .pid_err(pid_err),
    .len_err(len_err), .crc_err(crc_err), .kind_err(kind_err),
    .asm_busy(asm_busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (pkt_valid === 1'b1) vld_cnt++;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Bit list: PID LSB first, payload LSB first, then random filler (CRC / overflow).
  task automatic build(input logic [7:0] p, input logic [63:0] d, input int n);
    pkt_q.delete();
    for (int i = 0; i < n; i++) begin
      if (i < 8)       pkt_q.push_back(p[i]);
      else if (i < 72) pkt_q.push_back(d[i-8]);
      else             pkt_q.push_back(1'($urandom_range(0, 1)));
    end
  endtask

  task automatic feed_bits(input int n);
    for (int i = 0; i < n; i++) begin
      s_in = pkt_q[i];
      s_valid = 1'b1;
      step();
    end
    s_valid = 1'b0;
    s_in = 1'b0;
  endtask

  task automatic run_pkt(input logic rd, input logic rh, input logic crc, input int gap_mode,
                         input bit coinc, input bit start_end, input string tag);
    int n, cnt, v0;
    logic [7:0] ep;
    logic [63:0] ed;
    bit known, edat, ehs, epe, ele, ece, eke, eok, g;
    n = pkt_q.size();
    ep = '0;
    ed = '0;
    for (int i = 0; i < n; i++) begin
      if (i < 8)       ep[i] = pkt_q[i];
      else if (i < 72) ed[i-8] = pkt_q[i];
    end
    cnt  = (n > 127) ? 127 : n;
    edat = ep inside {8'hC3, 8'h4B};
    ehs  = ep inside {8'hD2, 8'h5A, 8'h1E};
    known = edat || ehs;
    epe  = !known || (ep[7:4] != ~ep[3:0]);
    ele  = epe || (edat && cnt != 88) || (ehs && cnt != 8);
    ece  = crc && edat;
    eke  = !epe && ((edat && !rd) || (ehs && !rh));
    eok  = !(epe || ele || ece || eke);

    v0 = vld_cnt;
    receive_data = rd;
    receive_hshake = rh;
    start_asm = 1'b1;
    end_asm = start_end;
    step();
    start_asm = 1'b0;
    end_asm = 1'b0;
    check({tag, ":busy_start"}, asm_busy, 1);
    check({tag, ":pid_clr"}, pid, 0);
    check({tag, ":len_clr"}, len_err, 0);

    for (int i = 0; i < n; i++) begin
      g = (gap_mode == 1) ? bit'(i % 2) : (gap_mode == 2) ? ($urandom_range(0, 2) == 0) : 1'b0;
      if (g) begin
        s_valid = 1'b0;
        step();
      end
      s_in = pkt_q[i];
      s_valid = 1'b1;
      if (coinc && i == n - 1) begin
        end_asm = 1'b1;
        rc_CRCerror = crc;
      end
      step();
      s_valid = 1'b0;
      s_in = 1'b0;
    end
    if (!(coinc && n > 0)) begin
      end_asm = 1'b1;
      rc_CRCerror = crc;
      step();
    end
    end_asm = 1'b0;
    rc_CRCerror = 1'b0;

    check({tag, ":pkt_valid"}, pkt_valid, 1);
    check({tag, ":pkt_ok"}, pkt_ok, eok);
    check({tag, ":pid"}, pid, ep);
    check({tag, ":data"}, data, ed);
    check({tag, ":pid_err"}, pid_err, epe);
    check({tag, ":len_err"}, len_err, ele);
    check({tag, ":crc_err"}, crc_err, ece);
    check({tag, ":kind_err"}, kind_err, eke);
    check({tag, ":busy_end"}, asm_busy, 0);
    step();
    check({tag, ":valid_drop"}, pkt_valid, 0);
    check({tag, ":ok_drop"}, pkt_ok, 0);
    check({tag, ":len_hold"}, len_err, ele);
    check({tag, ":kind_hold"}, kind_err, eke);
    check({tag, ":valid_count"}, 64'(vld_cnt - v0), 1);
  endtask

  initial begin
    logic [7:0]  rp;
    logic [63:0] rdat;
    int n, v0, sel;
    bit isd;

    rst_n = 1'b0;
    s_in = 1'b0; s_valid = 1'b0; start_asm = 1'b0; end_asm = 1'b0; abort = 1'b0;
    rc_CRCerror = 1'b0; receive_data = 1'b0; receive_hshake = 1'b0;
    #13;
    check("rst:outs", {pid, data[55:0]}, 0);
    check("rst:flags", {pkt_valid, pkt_ok, pid_err, len_err, crc_err, kind_err, asm_busy}, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    step();

    // Idle inputs are ignored.
    v0 = vld_cnt;
    s_valid = 1'b1; s_in = 1'b1; end_asm = 1'b1;
    repeat (3) step();
    s_valid = 1'b0; s_in = 1'b0; end_asm = 1'b0;
    step();
    check("idle:busy", asm_busy, 0);
    check("idle:pid", pid, 0);
    check("idle:valid_count", 64'(vld_cnt - v0), 0);

    // Directed cases from the test plan.
    build(8'hC3, 64'h7FFC_0000_0000_0000, 88);
    run_pkt(1, 0, 0, 0, 0, 0, "data0");
    build(8'hD2, 64'h0, 8);
    run_pkt(0, 1, 0, 0, 0, 0, "ack");
    build(8'hD2, 64'h0, 8);
    run_pkt(0, 0, 0, 0, 0, 0, "ack_kind");
    build(8'hC2, 64'h0, 8);
    run_pkt(1, 1, 0, 0, 0, 0, "bad_pid");
    build(8'h4B, {$urandom, $urandom}, 80);
    run_pkt(1, 0, 0, 0, 0, 0, "data1_short");
    build(8'hC3, {$urandom, $urandom}, 88);
    run_pkt(1, 0, 1, 0, 0, 0, "data0_crc");
    build(8'hD2, 64'h0, 8);
    run_pkt(0, 1, 0, 1, 1, 0, "ack_stall");
    build(8'hC3, {$urandom, $urandom}, 130);
    run_pkt(1, 0, 0, 0, 0, 0, "overflow");
    build(8'h1E, 64'h0, 8);
    run_pkt(0, 1, 1, 0, 1, 0, "stall_crc_ignored");

    // Abort after 30 DATA bits keeps partial contents, then a full ACK.
    rdat = {$urandom, $urandom};
    build(8'hC3, rdat, 88);
    v0 = vld_cnt;
    receive_data = 1'b1;
    start_asm = 1'b1; step(); start_asm = 1'b0;
    feed_bits(30);
    abort = 1'b1; step(); abort = 1'b0;
    check("abort:busy", asm_busy, 0);
    check("abort:pid", pid, 8'hC3);
    check("abort:data", data, rdat & 64'h3F_FFFF);
    check("abort:len_err", len_err, 0);
    repeat (3) step();
    check("abort:valid_count", 64'(vld_cnt - v0), 0);
    build(8'hD2, 64'h0, 8);
    run_pkt(0, 1, 0, 0, 0, 0, "after_abort");

    // Restart mid-packet with end_asm in the same cycle as start_asm.
    build(8'h4B, {$urandom, $urandom}, 88);
    start_asm = 1'b1; step(); start_asm = 1'b0;
    feed_bits(20);
    build(8'h5A, 64'h0, 8);
    run_pkt(0, 1, 0, 0, 0, 1, "restart");

    // Asynchronous reset mid-BODY.
    build(8'hC3, {$urandom, $urandom}, 88);
    v0 = vld_cnt;
    start_asm = 1'b1; step(); start_asm = 1'b0;
    feed_bits(40);
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid:pid_data", {pid, data}, 0);
    check("rst_mid:flags", {pkt_valid, pkt_ok, pid_err, len_err, crc_err, kind_err, asm_busy}, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    step();
    check("rst_mid:valid_count", 64'(vld_cnt - v0), 0);
    build(8'hD2, 64'h0, 8);
    run_pkt(0, 1, 0, 0, 0, 0, "after_rst");

    // Randomised packets.
    for (int k = 0; k < 40; k++) begin
      sel = $urandom_range(0, 5);
      case (sel)
        0: rp = 8'hC3;
        1: rp = 8'h4B;
        2: rp = 8'hD2;
        3: rp = 8'h5A;
        4: rp = 8'h1E;
        default: rp = 8'($urandom);
      endcase
      isd = (sel < 2);
      if ($urandom_range(0, 3) == 0) n = $urandom_range(0, 130);
      else n = isd ? 88 : 8;
      build(rp, {$urandom, $urandom}, n);
      run_pkt(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              2, (n > 0) && ($urandom_range(0, 1) == 1), 1'b0, $sformatf("rnd%0d", k));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rc_pkt_assembler.md
# rc_pkt_assembler

Receive-side packet assembler at the end of the USB host receive chain, directly downstream of `rc_crc`. Consumes the bit-serial, CRC-checked packet stream (PID, payload, CRC16; LSB first) and assembles it into a parallel PID byte and a 64-bit data word. At end of packet it classifies the packet, checks PID integrity, length and the expected packet kind. It then raises a one-cycle `pkt_valid` with error flags for the protocol FSM.

## Interface
- `PAYLOAD_BITS`, 64, DATA packet payload width in bits.
- `CRC_BITS`, 16, trailing CRC field width on DATA packets; counted and discarded.
- `clk`  in  1  system clock; all state changes on posedge.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `s_in`  in  1  serial bit from `rc_crc`.
- `s_valid`  in  1  `s_in` is a real bit this cycle; upstream may hold it low for stall cycles.
- `start_asm`  in  1  one-cycle pulse marking a new packet; the first bit arrives on a later `s_valid`.
- `end_asm`  in  1  one-cycle pulse marking that the packet has ended.
- `abort`  in  1  receive chain abort.
- `rc_CRCerror`  in  1  CRC verdict from `rc_crc`; sampled in the `end_asm` cycle.
- `receive_data`  in  1  host expects a DATA packet.
- `receive_hshake`  in  1  host expects a handshake packet.
- `pid`  out  8  received PID byte; first bit received is `pid[0]`.
- `data`  out  `PAYLOAD_BITS`  payload; first payload bit is `data[0]`.
- `pkt_valid`  out  1  one-cycle pulse when a packet is complete.
- `pkt_ok`  out  1  set with `pkt_valid` when no error flag is set.
- `pid_err`, `len_err`, `crc_err`, `kind_err`  out  1 each  error flags; held until the next `start_asm`.
- `asm_busy`  out  1  high from the cycle after `start_asm` through the `end_asm` cycle.

## Operation
- **FSM states.** The FSM has three states: IDLE, PID, BODY.
  - IDLE→PID on `start_asm`. This also clears `bit_cnt`, the shift registers and all error flags.
  - PID→BODY when the 8th valid bit is accepted.
  - PID or BODY→IDLE on `end_asm` or `abort`.
- **Bit counter.** `bit_cnt` is 7 bits and saturating. It increments on each accepted bit (`s_valid` in PID or BODY) and saturates at 127.
- **Bit placement.**
  - Valid bits 0–7 go to `pid[bit_cnt]`.
  - Bits 8 to 8+`PAYLOAD_BITS`−1 go to `data[bit_cnt−8]`.
  - Later bits are counted only.
- **Classification at `end_asm`.**
  - DATA: PID is C3 (DATA0) or 4B (DATA1).
  - HSHAKE: PID is D2 (ACK), 5A (NAK) or 1E (STALL).
- **Error checks at `end_asm`.**
  - `pid_err`: `pid[7:4]` != ~`pid[3:0]`, or the PID is not one of the five listed values.
  - `len_err`:
    - for DATA, `bit_cnt` != 8+`PAYLOAD_BITS`+`CRC_BITS` (88);
    - for HSHAKE, `bit_cnt` != 8;
    - `len_err` is also set whenever `pid_err` is set.
  - `crc_err`: `rc_CRCerror` and the packet is DATA.
  - `kind_err`: DATA received while `receive_data`=0, or HSHAKE received while `receive_hshake`=0. It is not set when `pid_err` is set.
- **Outputs.** `pid` and `data` hold their last assembled value until the next `start_asm` clears them to 0.

## Timing
- **Reset values.** All outputs are 0; the FSM is in IDLE; `bit_cnt` is 0.
- **Latency.** With `end_asm` in cycle N, `pkt_valid`, `pkt_ok` and the error flags are visible after posedge N+1. `pkt_valid` is high for exactly one cycle.
- **Simultaneous events.**
  - `s_valid` together with `end_asm`: the bit is accepted first, then evaluation uses the updated count and registers.
  - `start_asm` outranks `end_asm` and `abort` in the same cycle. The current packet is discarded with no `pkt_valid`, and a new packet begins.
  - `start_asm` while in PID or BODY: restart, with no `pkt_valid` for the dropped packet.
- **Abort.** `abort` in PID or BODY: go to IDLE next cycle with no `pkt_valid`. Flags stay cleared; `pid` and `data` keep their partial contents. `abort` in IDLE has no effect.
- **Idle inputs.** `end_asm` or `s_valid` in IDLE is ignored.
- **Overflow.** Bits beyond 88 are dropped; the count saturates and `len_err` is guaranteed at end.
- **Reset mid-packet.** Immediately returns the block to its reset state.

## Test plan
- **DATA0.** `receive_data`=1; send PID C3, then payload 64'h7FFC_0000_0000_0000 LSB-first, then 16 CRC bits; then `end_asm` with `rc_CRCerror`=0.
  → `pid`=C3, `data`=64'h7FFC_0000_0000_0000, `pkt_valid` and `pkt_ok` high for 1 cycle at N+1.
- **ACK.** `receive_hshake`=1; send D2, then `end_asm`.
  → `pkt_ok`=1, `data`=0.
  Repeat with `receive_hshake`=0.
  → `kind_err`=1, `pkt_ok`=0.
- **Errors.**
  - PID 8'hC2. → `pid_err`=1, `len_err`=1.
  - DATA1 4B with only 80 bits. → `len_err`=1.
  - DATA0 with `rc_CRCerror`=1. → `crc_err`=1 only.
- **Stall cycles.** ACK with `s_valid` low on alternate cycles, and the last bit coincident with `end_asm`.
  → Same result as the ungapped case.
- **Abort and restart.** `abort` after 30 DATA bits, then a new `start_asm` with a full ACK.
  → No `pkt_valid` for the first packet; exactly one `pkt_valid` with `pkt_ok`=1 for the ACK.
- **Reset.** Assert `rst_n` low mid-BODY.
  → All outputs 0 asynchronously; the next packet is received correctly.
